// File: rtl/rr_mux4.sv
// rr_mux4: four-lane round-robin arbiter feeding a one-entry registered output.
// Latency: a word accepted at edge N is on out_data/select with out_valid=1 after edge N.
// Backpressure: in_ready is one-hot or zero. It is zero while the output holds an unread word, or during rst.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid[3:0]   per-lane offer; in_data lane i at [i*WIDTH +: WIDTH]
//   in_ready[3:0]   one-hot accept strobe for the granted lane
//   out_valid/out_data/select  registered output word and its source lane
//   out_ready       downstream accepts the held word this cycle
module rr_mux4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         select,
  input  logic               out_ready
);

  logic [1:0]       ptr;
  logic             load;
  logic             found;
  logic [1:0]       gnt;
  logic [1:0]       idx;
  logic [WIDTH-1:0] lane [4];

  // The output register can take a new word when it is empty or being drained.
  assign load = ~out_valid | out_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Scan from ptr upward with a 2-bit wrap. The first valid lane wins.
  always_comb begin
    found = 1'b0;
    gnt   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  // rst gates the strobe so no upstream word is consumed during a reset edge.
  always_comb begin
    in_ready = 4'b0000;
    if (load && found && !rst) begin
      in_ready[gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      select    <= 2'd0;
      ptr       <= 2'd0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= lane[gnt];
        select    <= gnt;
        ptr       <= gnt + 2'd1;
      end else begin
        // Nothing offered: drop valid, keep the last word and the pointer.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux4.sv
// tb_rr_mux4: directed self-checking bench for rr_mux4.
// Inputs are driven on the falling edge. in_ready is checked before the rising edge.
// Registered outputs are checked 1ns after the rising edge.
module tb_rr_mux4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  select;
  logic        out_ready;

  int tests  = 0;
  int failed = 0;

  localparam logic [31:0] BASE = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  rr_mux4 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .select    (select),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle. Check in_ready, clock once, then check the registered outputs.
  task automatic cyc(input string tag, input logic r, input logic [3:0] v, input logic ordy,
                     input logic [3:0] exp_rdy, input logic exp_ov,
                     input logic [7:0] exp_dat, input logic [1:0] exp_sel);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    out_ready = ordy;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    check({tag, ".out_data"}, 32'(out_data), 32'(exp_dat));
    check({tag, ".select"}, 32'(select), 32'(exp_sel));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_data   = BASE;
    out_ready = 1'b1;

    // Reset for two cycles with every lane requesting.
    cyc("rst0", 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    cyc("rst1", 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);

    // Rotation: 0,1,2,3,0.
    cyc("rot0", 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    cyc("rot1", 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
    cyc("rot2", 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2);
    cyc("rot3", 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3);
    cyc("rot4", 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);

    // Load A1. Then stall for three cycles. Then release: lane 2 comes next.
    cyc("bp_ld", 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
    cyc("bp_h0", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1);
    cyc("bp_h1", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1);
    cyc("bp_h2", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1);
    cyc("bp_go", 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2);

    // A lane-3 grant moves ptr to 0. Sparse requests follow, then idle.
    cyc("sp_l3",  1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3);
    cyc("sp_l2",  1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2);
    cyc("sp_wr",  1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    cyc("sp_idl", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0);

    // A single active lane streams with no bubbles. Each word is distinct.
    for (int k = 0; k < 4; k++) begin
      in_data = {8'hA3, 8'hA2, 8'(8'h10 + k), 8'hA0};
      cyc($sformatf("one%0d", k), 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'(8'h10 + k), 2'd1);
    end
    in_data = BASE;

    // Reset while lane 2's word is held. Afterwards arbitration restarts at lane 0.
    cyc("mr_ld",  1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2);
    cyc("mr_rst", 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
    cyc("mr_g0",  1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    cyc("mr_g1",  1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);

    // Reset has priority over a drain-and-load edge.
    cyc("rp_rst", 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rr_mux4.md
RR_MUX4 -- requirements
Module: rr_mux4

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each lane and of the output.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  4  bit i high: lane i offers a word.
REQ-006 in_data  input  4*WIDTH  lane i word at bits [i*WIDTH +: WIDTH].
REQ-007 in_ready  output  4  bit i high: lane i word accepted this cycle (transfer = in_valid[i] & in_ready[i]).
REQ-008 out_valid  output  1  out_data/select hold a word.
REQ-009 out_data  output  WIDTH  registered output word.
REQ-010 select  output  2  index of the lane that supplied out_data.
REQ-011 out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-012 One-entry output register; load = ~out_valid | out_ready (combinational).
REQ-013 Round-robin pointer ptr (2 bits) names the highest-priority lane; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 Grant = first lane in search order with in_valid set; grant is computed combinationally from the current in_valid and ptr.
REQ-015 in_ready SHALL be one-hot or zero; in_ready[g] = load & in_valid[g] for granted lane g; all other bits 0.
REQ-016 in_ready SHALL NOT depend on in_data.
REQ-017 On a clock edge with load and a grant g: out_data <= lane g word; select <= g; out_valid <= 1; ptr <= g+1 mod 4 (3 wraps to 0).
REQ-018 On a clock edge with load and no in_valid bit set: out_valid <= 0; ptr, out_data and select hold.
REQ-019 On a clock edge without load (out_valid=1, out_ready=0): out_valid, out_data, select and ptr hold; in_ready = 0000.
REQ-020 Latency: a lane word accepted at edge N appears on out_data/select with out_valid=1 after edge N.
REQ-021 Throughput: one word per cycle while out_ready=1 and any in_valid is set.
REQ-022 Simultaneous pop and push (out_valid=1, out_ready=1, grant present): the held word leaves and the new word loads on the same edge, with no bubble.
REQ-023 Fairness: with all four lanes continuously valid and out_ready=1, grants SHALL follow ptr order cyclically, and no lane SHALL wait more than 3 grants.
REQ-024 Single valid lane: that lane SHALL be granted every loadable cycle regardless of ptr.
REQ-025 A lane that drops in_valid before it is granted SHALL lose nothing; no state records pending requests.

Reset
REQ-026 While rst=1 at a clock edge: out_valid <= 0, out_data <= 0, select <= 0, ptr <= 0.
REQ-027 While rst=1, in_ready SHALL be 0000 regardless of other inputs.
REQ-028 Reset takes priority over all loads; a word held or being accepted on a reset edge is discarded.
REQ-029 On the first edge after rst falls, arbitration starts from lane 0.

Verification
REQ-030 Reset: assert rst for 2 cycles with in_valid=1111 -> in_ready=0000, out_valid=0, out_data=0, select=0.
REQ-031 Rotation: in_valid=1111, lane i data = 8'hA0+i, out_ready=1 for 5 cycles -> select sequence 0,1,2,3,0; out_data A0,A1,A2,A3,A0; in_ready 0001,0010,0100,1000,0001.
REQ-032 Backpressure: hold word 8'hA1 (select=1), out_ready=0 for 3 cycles, in_valid=1111 -> out_data stays A1, select stays 1, in_ready=0000; after out_ready=1, next grant goes to lane 2.
REQ-033 Sparse/wrap: after a lane-3 grant (ptr=0), in_valid=0100 -> grant lane 2, select=2; then in_valid=0001 -> grant lane 0; then in_valid=0000 with out_ready=1 -> out_valid=0 on the next edge.
REQ-034 Single lane: in_valid=0010, out_ready=1 for 4 cycles -> 4 consecutive words from lane 1, in_ready=0010 every cycle, no bubbles.
REQ-035 Reset mid-operation: out_valid=1 holding lane-2 word, assert rst for 1 cycle -> out_valid=0; with in_valid=1111 after release, the first grant goes to lane 0.
